// File: rtl/snn_spike_aer_tx.sv
// snn_spike_aer_tx: address-event transmitter for the LIF SNN core output.
//
// Once per timestep the core's N-bit spike vector is captured and then
// serialised, lowest neuron index first, into a valid/ready stream of neuron
// addresses. Every beat carries the timestamp of the step it belongs to.
// Steps offered while a previous step is still draining are dropped. Dropped
// steps still consume a timestamp, and they are counted in ovf_cnt.
//
// Optional feature macro: AER_STEP_MARKER_EN
//   defined   : every accepted step, including an empty one, is closed by an
//               end-of-step marker beat (aer_eos=1, aer_addr=0).
//   undefined : no marker beat; aer_eos is tied to 0. Empty steps emit nothing.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   step_valid   spikes_vec holds a new timestep result this cycle
//   spikes_vec   spike vector, bit n = neuron n fired
//   step_ready   block can accept a step this cycle (state is idle)
//   aer_valid    event beat valid
//   aer_ready    downstream accepts beat
//   aer_addr     neuron index of beat (0 on marker beat)
//   aer_ts       timestamp of the step the beat belongs to
//   aer_eos      beat is end-of-step marker
//   busy         a step is being transmitted
//   ovf_cnt      saturating count of dropped steps
module snn_spike_aer_tx #(
  parameter int unsigned N     = 96,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned OVF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_valid,
  input  logic [N-1:0]         spikes_vec,
  output logic                 step_ready,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [$clog2(N)-1:0] aer_addr,
  output logic [TS_W-1:0]      aer_ts,
  output logic                 aer_eos,
  output logic                 busy,
  output logic [OVF_W-1:0]     ovf_cnt
);

  localparam int unsigned AW = $clog2(N);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
`ifdef AER_STEP_MARKER_EN
  localparam logic [1:0] StEos  = 2'd2;
  // Where the FSM goes once a step has no spikes left to send.
  localparam logic [1:0] StDone = StEos;
`else
  localparam logic [1:0] StDone = StIdle;
`endif

  logic [1:0]      state;
  logic [N-1:0]    mask;
  logic [TS_W-1:0] ts_cnt;
  logic [N-1:0]    mask_rest;
  logic [AW-1:0]   addr_lo;

  // Index of the lowest set bit. This is 0 when the mask is empty. The mask is
  // only ever loaded from spikes_vec, so the index cannot exceed N-1.
  always_comb begin
    addr_lo = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask[i]) addr_lo = AW'(i);
    end
  end

  // Clearing the lowest set bit with x & (x-1) avoids a decoder.
  assign mask_rest = mask & (mask - N'(1));

  assign step_ready = (state == StIdle);
  assign busy       = (state != StIdle);
  assign aer_valid  = (state != StIdle);
  assign aer_addr   = (state == StScan) ? addr_lo : '0;
`ifdef AER_STEP_MARKER_EN
  assign aer_eos    = (state == StEos);
`else
  assign aer_eos    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      mask    <= '0;
      ts_cnt  <= '0;
      ovf_cnt <= '0;
      aer_ts  <= '0;
    end else begin
      // Every offered step consumes a timestamp. A dropped step therefore
      // shows up as a gap in the timestamps the consumer sees.
      if (step_valid) ts_cnt <= ts_cnt + 1'b1;
      if (step_valid && !step_ready && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;

      case (state)
        StIdle: begin
          if (step_valid) begin
            mask   <= spikes_vec;
            aer_ts <= ts_cnt;
            state  <= (|spikes_vec) ? StScan : StDone;
          end
        end
        StScan: begin
          if (aer_ready) begin
            mask <= mask_rest;
            if (mask_rest == '0) state <= StDone;
          end
        end
`ifdef AER_STEP_MARKER_EN
        StEos: begin
          if (aer_ready) state <= StIdle;
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_spike_aer_tx.sv
module tb_snn_spike_aer_tx;

  localparam int unsigned N     = 96;
  localparam int unsigned TS_W  = 4;
  localparam int unsigned OVF_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             step_valid;
  logic [N-1:0]     spikes_vec;
  logic             step_ready;
  logic             aer_valid;
  logic             aer_ready;
  logic [6:0]       aer_addr;
  logic [TS_W-1:0]  aer_ts;
  logic             aer_eos;
  logic             busy;
  logic [OVF_W-1:0] ovf_cnt;

  int checks   = 0;
  int failures = 0;

  logic [TS_W-1:0] exp_ts;
  logic [TS_W-1:0] t;
  logic [N-1:0]    m;

  snn_spike_aer_tx #(
    .N    (N),
    .TS_W (TS_W),
    .OVF_W(OVF_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_valid(step_valid),
    .spikes_vec(spikes_vec),
    .step_ready(step_ready),
    .aer_valid (aer_valid),
    .aer_ready (aer_ready),
    .aer_addr  (aer_addr),
    .aer_ts    (aer_ts),
    .aer_eos   (aer_eos),
    .busy      (busy),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one step from idle. ts returns the timestamp the step should carry.
  task automatic send_step(input logic [N-1:0] v, output logic [TS_W-1:0] ts);
    chk("step_ready_pre", 32'(step_ready), 32'd1);
    ts         = exp_ts;
    step_valid = 1'b1;
    spikes_vec = v;
    tick();
    step_valid = 1'b0;
    spikes_vec = '0;
    exp_ts     = exp_ts + 1'b1;
  endtask

  // Drain the beats of mask v under continuous aer_ready, then check for idle.
  task automatic expect_beats(input logic [N-1:0] v, input logic [TS_W-1:0] ts);
    aer_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) begin
        chk("beat_valid", 32'(aer_valid), 32'd1);
        chk("beat_addr", 32'(aer_addr), 32'(i));
        chk("beat_ts", 32'(aer_ts), 32'(ts));
        chk("beat_eos", 32'(aer_eos), 32'd0);
        chk("beat_busy", 32'(busy), 32'd1);
        tick();
      end
    end
`ifdef AER_STEP_MARKER_EN
    chk("eos_valid", 32'(aer_valid), 32'd1);
    chk("eos_flag", 32'(aer_eos), 32'd1);
    chk("eos_addr", 32'(aer_addr), 32'd0);
    chk("eos_ts", 32'(aer_ts), 32'(ts));
    tick();
`endif
    chk("idle_valid", 32'(aer_valid), 32'd0);
    chk("idle_ready", 32'(step_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    step_valid = 1'b0;
    spikes_vec = '0;
    aer_ready  = 1'b0;
    exp_ts     = '0;
    tick();
    tick();
    chk("rst_valid", 32'(aer_valid), 32'd0);
    chk("rst_addr", 32'(aer_addr), 32'd0);
    chk("rst_ts", 32'(aer_ts), 32'd0);
    chk("rst_eos", 32'(aer_eos), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_step_ready", 32'(step_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Bits {3,0,95}: ascending beats at ts 0.
    m = '0; m[3] = 1'b1; m[0] = 1'b1; m[95] = 1'b1;
    send_step(m, t);
    chk("t1_ts0", 32'(t), 32'd0);
    expect_beats(m, t);

    // Advance to ts 5, then send an empty step.
    for (int s = 1; s <= 4; s++) begin
      m = '0; m[s * 7] = 1'b1;
      send_step(m, t);
      expect_beats(m, t);
    end
    send_step('0, t);
    chk("t2_ts5", 32'(t), 32'd5);
    expect_beats('0, t);

    // Backpressure with addr 7 pending at ts 6.
    m = '0; m[2] = 1'b1; m[7] = 1'b1; m[40] = 1'b1;
    send_step(m, t);
    chk("t3_ts6", 32'(t), 32'd6);
    aer_ready = 1'b1;
    chk("bp_first_addr", 32'(aer_addr), 32'd2);
    tick();
    aer_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_valid", 32'(aer_valid), 32'd1);
      chk("bp_addr", 32'(aer_addr), 32'd7);
      chk("bp_ts", 32'(aer_ts), 32'd6);
      tick();
    end
    m[2] = 1'b0;
    expect_beats(m, t);

    // Overflow: a step offered while a 10-spike step drains is dropped.
    m = '0;
    for (int i = 10; i < 20; i++) m[i] = 1'b1;
    send_step(m, t);
    chk("t4_ts7", 32'(t), 32'd7);
    aer_ready  = 1'b1;
    step_valid = 1'b1;
    spikes_vec = '0;
    spikes_vec[50] = 1'b1;
    chk("drop_step_ready", 32'(step_ready), 32'd0);
    chk("drop_addr", 32'(aer_addr), 32'd10);
    tick();
    step_valid = 1'b0;
    spikes_vec = '0;
    exp_ts     = exp_ts + 1'b1;
    chk("ovf_one", 32'(ovf_cnt), 32'd1);
    m[10] = 1'b0;
    expect_beats(m, t);
    m = '0; m[1] = 1'b1;
    send_step(m, t);
    chk("t4_gap_ts9", 32'(t), 32'd9);
    expect_beats(m, t);

    // Saturation of the 2-bit drop counter while stalled.
    m = '0;
    for (int i = 20; i < 28; i++) m[i] = 1'b1;
    send_step(m, t);
    aer_ready  = 1'b0;
    step_valid = 1'b1;
    tick();
    chk("ovf_two", 32'(ovf_cnt), 32'd2);
    tick();
    chk("ovf_three", 32'(ovf_cnt), 32'd3);
    tick();
    chk("ovf_sat", 32'(ovf_cnt), 32'd3);
    chk("sat_addr_hold", 32'(aer_addr), 32'd20);
    step_valid = 1'b0;
    exp_ts     = exp_ts + 3'd3;
    expect_beats(m, t);

    // Reset in the middle of a scan with 5 bits still pending.
    m = '0;
    for (int i = 30; i < 36; i++) m[i] = 1'b1;
    send_step(m, t);
    aer_ready = 1'b1;
    tick();
    aer_ready = 1'b0;
    chk("pre_rst_addr", 32'(aer_addr), 32'd31);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ts = '0;
    chk("mid_rst_valid", 32'(aer_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("mid_rst_ts", 32'(aer_ts), 32'd0);
    aer_ready = 1'b1;
    tick();
    chk("post_rst_quiet", 32'(aer_valid), 32'd0);

    // Timestamp wrap at 4 bits: ts 0..15, then 0 with an all-ones vector.
    for (int s = 0; s < 16; s++) begin
      m = '0; m[s * 5 + 1] = 1'b1;
      send_step(m, t);
      chk("wrap_ts_seq", 32'(t), 32'(s));
      expect_beats(m, t);
    end
    m = '1;
    send_step(m, t);
    chk("wrap_ts_zero", 32'(t), 32'd0);
    expect_beats(m, t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
